demand_scheduler: RTL and testbench

- Arbitrates approach-sensor demands for the intersection phase sequencer. The sensors are Thevenin, Norton-north and Norton-south.
- Debounces the raw sensor inputs and latches each demand as a pending request.
- At each cycle boundary, when the sequencer asks, it offers one green-extension selection over a valid/ack handshake.
- Sits between the sensor pins and the phase sequencer's table-select input.

---
 rtl/demand_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_demand_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demand_scheduler.sv
// demand_scheduler
//   Arbitrates approach-sensor demands (Thevenin, Norton-north, Norton-south)
//   for the intersection phase sequencer. Raw sensor levels are double-flopped
//   and debounced. Each debounced rising edge latches a pending request. When
//   the sequencer asks, one green-extension selection is offered over a
//   valid/ack handshake.
//
//   Optional feature: define DEMAND_SCHED_STARVE_EN to enable skip counters.
//   With the feature on, a channel that has lost MAX_SKIP grants while pending
//   is forced ahead of fixed priority.
//
// Ports
//   clk          in   system clock (10 kHz)
//   reset        in   synchronous, active-high
//   enable       in   intersection enabled; low idles the block and clears demands
//   sensor       in   [N_REQ] raw sensor levels (asynchronous origin)
//   phase_req    in   sequencer requests a selection (sampled only in IDLE)
//   phase_ack    in   sequencer accepts the current offer
//   grant_valid  out  offer valid
//   grant_idx    out  [IDX_W] 0 = no demand (default table), k = channel k-1
//   pending      out  [N_REQ] latched demand bits
//   starved      out  one-cycle pulse on the first cycle of a forced grant
module demand_scheduler #(
    parameter int N_REQ           = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_SKIP        = 2,
    parameter int IDX_W           = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_REQ-1:0] sensor,
    input  logic             phase_req,
    input  logic             phase_ack,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N_REQ-1:0] pending,
    output logic             starved
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DECIDE, S_OFFER} state_e;

    generate
        if (IDX_W < $clog2(N_REQ + 1) || MAX_SKIP < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
            $error("demand_scheduler: illegal parameter combination");
        end
    endgenerate

    state_e                      state_q, state_d;
    logic [N_REQ-1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N_REQ-1:0]            deb_q, deb_d, rise;
    logic [N_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0]            pending_q, pending_d, clr;
    logic                        grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]            grant_idx_q, grant_idx_d, arb_idx;
    logic                        handshake;

`ifdef DEMAND_SCHED_STARVE_EN
    localparam int SKIP_W = $clog2(MAX_SKIP + 1);
    localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(MAX_SKIP);

    logic [N_REQ-1:0][SKIP_W-1:0] skip_q, skip_d;
    logic                         forced_q, forced_d;
    logic                         starved_q, starved_d;
    logic                         arb_forced;
`endif

    // grant_valid is only ever high in OFFER, so it alone qualifies the ack.
    assign handshake = grant_valid_q & phase_ack;

    // Synchronizer and per-channel debounce.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        sync1_d = sensor;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        rise    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                    rise[i]  = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
        if (!enable) begin
            sync1_d = '0;
            sync2_d = '0;
            deb_d   = '0;
            cnt_d   = '0;
            rise    = '0;
        end
    end

    // Demand latch: a rise in the same cycle as its own clear wins.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (handshake && grant_idx_q == IDX_W'(i + 1)) clr[i] = 1'b1;
        end
        pending_d = (pending_q & ~clr) | rise;
        if (!enable) pending_d = '0;
    end

    // Arbitration on the current pending vector; aged channels override priority.
    always_comb begin
        arb_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pending_q[i]) arb_idx = IDX_W'(i + 1);
        end
`ifdef DEMAND_SCHED_STARVE_EN
        arb_forced = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (skip_q[i] == SKIP_MAX) begin
                arb_idx    = IDX_W'(i + 1);
                arb_forced = 1'b1;
            end
        end
`endif
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (phase_req) state_d = S_DECIDE;
            S_DECIDE: state_d = S_OFFER;
            S_OFFER:  if (handshake) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (!enable) state_d = S_IDLE;
    end

    // FSM: registered outputs. The offer is latched leaving DECIDE and
    // grant_valid follows one cycle into OFFER, so an ack is only honoured
    // once the sequencer can actually see the offer.
    always_comb begin
        grant_valid_d = 1'b0;
        grant_idx_d   = grant_idx_q;
        case (state_q)
            S_DECIDE: grant_idx_d   = arb_idx;
            S_OFFER:  grant_valid_d = !handshake;
            default:  grant_valid_d = 1'b0;
        endcase
        if (!enable) begin
            grant_valid_d = 1'b0;
            grant_idx_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            deb_q         <= '0;
            // NOTE: the counter arrays are per-channel control state, not storage, so they are reset.
            cnt_q         <= '0;
            pending_q     <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            deb_q         <= deb_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
        end
    end

`ifdef DEMAND_SCHED_STARVE_EN
    // Skip ageing on completed handshakes, plus the forced-grant pulse.
    always_comb begin
        skip_d = skip_q;
        if (handshake) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_idx_q == IDX_W'(i + 1) || !pending_q[i]) skip_d[i] = '0;
                else if (skip_q[i] != SKIP_MAX)                    skip_d[i] = skip_q[i] + 1'b1;
            end
        end
        forced_d  = (state_q == S_DECIDE) ? arb_forced : forced_q;
        starved_d = (state_q == S_OFFER) && !grant_valid_q && forced_q;
        if (!enable) begin
            skip_d    = '0;
            forced_d  = 1'b0;
            starved_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skip_q    <= '0;
            forced_q  <= 1'b0;
            starved_q <= 1'b0;
        end else begin
            skip_q    <= skip_d;
            forced_q  <= forced_d;
            starved_q <= starved_d;
        end
    end

    assign starved = starved_q;
`else
    assign starved = 1'b0;
`endif

    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_demand_scheduler.sv
`timescale 1us/1ns
// Self-checking bench for demand_scheduler: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// behavioural model (delay line + stability window + offer timeline).
module tb_demand_scheduler;
    localparam int N_REQ    = 3;
    localparam int DEB      = 16;
    localparam int MAX_SKIP = 2;
    localparam int IDX_W    = 2;

    logic             clk = 1'b0;
    logic             reset, enable, phase_req, phase_ack;
    logic [N_REQ-1:0] sensor;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [N_REQ-1:0] pending;
    logic             starved;

    int n_cmp = 0;
    int n_bad = 0;

    demand_scheduler #(
        .N_REQ(N_REQ), .DEBOUNCE_CYCLES(DEB), .MAX_SKIP(MAX_SKIP), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .sensor(sensor),
        .phase_req(phase_req), .phase_ack(phase_ack),
        .grant_valid(grant_valid), .grant_idx(grant_idx),
        .pending(pending), .starved(starved)
    );

    always #50 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N_REQ-1:0] m_pipe[$];   // two-sample delay from pin to debouncer
    logic [N_REQ-1:0] m_hist[$];   // most recent delayed samples since clear
    logic [N_REQ-1:0] m_level, m_pending;
    int               m_skip[N_REQ];
    int               m_age;       // edges since request accepted, -1 when idle
    int               m_idx;
    logic             m_gv, m_starved, m_forced, m_idx_zero;
    bit               started = 0;

    task automatic model_clear();
        m_pipe.delete();
        m_pipe.push_back('0);
        m_pipe.push_back('0);
        m_hist.delete();
        m_level    = '0;
        m_pending  = '0;
        for (int i = 0; i < N_REQ; i++) m_skip[i] = 0;
        m_age      = -1;
        m_idx      = 0;
        m_gv       = 1'b0;
        m_starved  = 1'b0;
        m_forced   = 1'b0;
        m_idx_zero = 1'b1;
    endtask

    task automatic model_step();
        logic [N_REQ-1:0] s, rise, pend_pre;
        logic             hs;
        bit               all_opp;
        if (reset || !enable) begin
            model_clear();
            return;
        end
        s = m_pipe.pop_front();
        m_pipe.push_back(sensor);
        m_hist.push_back(s);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        // A level flips once the last DEB delayed samples all disagree with it.
        rise = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (m_hist.size() == DEB) begin
                all_opp = 1;
                foreach (m_hist[k]) if (m_hist[k][i] == m_level[i]) all_opp = 0;
                if (all_opp) begin
                    m_level[i] = ~m_level[i];
                    rise[i]    = m_level[i];
                end
            end
        end
        pend_pre = m_pending;
        hs = m_gv && phase_ack;
        for (int i = 0; i < N_REQ; i++) if (hs && m_idx == i + 1) m_pending[i] = 1'b0;
        m_pending = m_pending | rise;
`ifdef DEMAND_SCHED_STARVE_EN
        if (hs) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (m_idx == i + 1 || !pend_pre[i]) m_skip[i] = 0;
                else if (m_skip[i] < MAX_SKIP)      m_skip[i]++;
            end
        end
`endif
        m_starved = 1'b0;
        if (m_age < 0) begin
            if (phase_req) m_age = 0;
        end else begin
            m_age++;
            if (m_age == 1) begin
                m_idx      = 0;
                m_forced   = 1'b0;
                m_idx_zero = 1'b0;
                for (int i = N_REQ - 1; i >= 0; i--) if (pend_pre[i]) m_idx = i + 1;
`ifdef DEMAND_SCHED_STARVE_EN
                for (int i = N_REQ - 1; i >= 0; i--) begin
                    if (m_skip[i] == MAX_SKIP) begin
                        m_idx    = i + 1;
                        m_forced = 1'b1;
                    end
                end
`endif
            end else if (m_age == 2) begin
                m_gv      = 1'b1;
                m_starved = m_forced;
            end else if (hs) begin
                m_gv  = 1'b0;
                m_age = -1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        started = 1;
    end

    // Single per-cycle compare process, sampled on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            check("grant_valid", {31'b0, grant_valid}, {31'b0, m_gv});
            check("pending", {29'b0, pending}, {29'b0, m_pending});
            check("starved", {31'b0, starved}, {31'b0, m_starved});
            if (m_gv || m_idx_zero) check("grant_idx", {30'b0, grant_idx}, m_idx);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic get_offer(output int idx, output int st);
        int n;
        phase_req = 1'b1;
        @(negedge clk);
        phase_req = 1'b0;
        n = 0;
        while (grant_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("offer_within_bound", {31'b0, grant_valid}, 1);
        idx = int'(grant_idx);
        st  = int'(starved);
    endtask

    task automatic ack_now();
        phase_ack = 1'b1;
        @(negedge clk);
        phase_ack = 1'b0;
    endtask

    task automatic do_round(input int ack_wait, output int idx, output int st);
        get_offer(idx, st);
        repeat (ack_wait) @(negedge clk);
        ack_now();
    endtask

    task automatic pulse_sensor(input logic [N_REQ-1:0] bits);
        sensor = bits;
        repeat (18) @(negedge clk);
        sensor = '0;
        repeat (22) @(negedge clk);
    endtask

    int idx, st;

    initial begin
        reset = 1'b1; enable = 1'b1; sensor = 3'b111; phase_req = 1'b0; phase_ack = 1'b0;

        // Reset with sensors active.
        repeat (2) @(negedge clk);
        check("rst_gv", {31'b0, grant_valid}, 0);
        check("rst_idx", {30'b0, grant_idx}, 0);
        check("rst_pending", {29'b0, pending}, 0);
        check("rst_starved", {31'b0, starved}, 0);
        reset = 1'b0;
        sensor = '0;
        repeat (3) @(negedge clk);

        // Empty offer: two-edge latency, idx 0, nothing cleared.
        phase_req = 1'b1;
        @(negedge clk);
        phase_req = 1'b0;
        @(negedge clk);
        check("empty_not_yet", {31'b0, grant_valid}, 0);
        @(negedge clk);
        check("empty_gv", {31'b0, grant_valid}, 1);
        check("empty_idx", {30'b0, grant_idx}, 0);
        repeat (3) @(negedge clk);
        check("empty_held", {31'b0, grant_valid}, 1);
        ack_now();
        check("empty_gv_drop", {31'b0, grant_valid}, 0);
        check("empty_pending", {29'b0, pending}, 0);

        // Debounce: 15 cycles is too short, the 16th stable sample latches.
        sensor[1] = 1'b1;
        repeat (15) @(negedge clk);
        sensor[1] = 1'b0;
        repeat (25) @(negedge clk);
        check("deb_short", {29'b0, pending}, 0);
        sensor[1] = 1'b1;
        repeat (17) @(negedge clk);
        check("deb_edge_minus1", {29'b0, pending}, 0);
        @(negedge clk);
        check("deb_edge", {29'b0, pending}, 3'b010);
        sensor[1] = 1'b0;
        repeat (22) @(negedge clk);

        // Fixed priority on 3'b110.
        pulse_sensor(3'b100);
        check("prio_pending", {29'b0, pending}, 3'b110);
        do_round(1, idx, st);
        check("prio_r1_idx", idx, 2);
        check("prio_r1_pending", {29'b0, pending}, 3'b100);
        do_round(0, idx, st);
        check("prio_r2_idx", idx, 3);
        check("prio_r2_pending", {29'b0, pending}, 3'b000);
        do_round(2, idx, st);
        check("prio_r3_idx", idx, 0);

        // Set wins over clear in the ack cycle.
        pulse_sensor(3'b001);
        get_offer(idx, st);
        check("setwin_idx", idx, 1);
        sensor[0] = 1'b1;
        repeat (17) @(negedge clk);
        ack_now();
        check("setwin_gv", {31'b0, grant_valid}, 0);
        check("setwin_pending", {29'b0, pending}, 3'b001);

        // Enable drop mid-offer abandons the offer and clears demands.
        get_offer(idx, st);
        check("en_offer_idx", idx, 1);
        enable = 1'b0;
        sensor = '0;
        @(negedge clk);
        check("en_gv", {31'b0, grant_valid}, 0);
        check("en_pending", {29'b0, pending}, 0);
        check("en_idx", {30'b0, grant_idx}, 0);
        enable = 1'b1;
        repeat (5) @(negedge clk);

        // Starvation: channel 2 waits while channel 0 keeps re-triggering.
        pulse_sensor(3'b101);
        do_round(1, idx, st);
        check("starve_r1_idx", idx, 1);
        check("starve_r1_st", st, 0);
        pulse_sensor(3'b001);
        do_round(1, idx, st);
        check("starve_r2_idx", idx, 1);
        check("starve_r2_st", st, 0);
        pulse_sensor(3'b001);
        do_round(1, idx, st);
`ifdef DEMAND_SCHED_STARVE_EN
        check("starve_r3_idx", idx, 3);
        check("starve_r3_st", st, 1);
`else
        check("starve_r3_idx", idx, 1);
        check("starve_r3_st", st, 0);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N_REQ; i++) if ($urandom_range(0, 19) == 0) sensor[i] = ~sensor[i];
            phase_req = ($urandom_range(0, 3) == 0);
            phase_ack = ($urandom_range(0, 2) == 0);
            enable    = ($urandom_range(0, 299) != 0);
            reset     = ($urandom_range(0, 799) == 0);
        end
        reset = 1'b0; enable = 1'b1; phase_req = 1'b0; phase_ack = 1'b0; sensor = '0;
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
